// File: rtl/cl_mem_src_pkg.sv
// ============================================================================
// Module : cl_mem_src_pkg
// Brief  : Shared types and helpers for the DDR port source controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cl_mem_src_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCRB  = 2'd1,
    ATG   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  function automatic int cnt_width(input int max_os);
    return $clog2(max_os + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cl_mem_os_cnt.sv
// ============================================================================
// Module : cl_mem_os_cnt
// Brief  : Saturating outstanding-burst counter with under/overflow pulse.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cl_mem_os_cnt #(
  parameter int MAX_OS = 64,
  parameter int CW     = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          err
);

  localparam logic [CW-1:0] C_MAX = CW'(MAX_OS);

  logic [CW-1:0] r_cnt;
  logic          w_up;
  logic          w_dn;

  // inc and dec together cancel out
  assign w_up = inc & ~dec;
  assign w_dn = dec & ~inc;
  assign err  = ~clr & ((w_up & (r_cnt == C_MAX)) | (w_dn & (r_cnt == '0)));
  assign cnt  = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (w_up && (r_cnt != C_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (w_dn && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cl_mem_src_ctl.sv
// ============================================================================
// Module : cl_mem_src_ctl
// Brief  : Arbitrates the DDR AXI master port between scrubber, ATG and slave
//          path, draining outstanding bursts before every ownership change.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cl_mem_src_ctl
  import cl_mem_src_pkg::*;
#(
  parameter int MAX_OS        = 64,
  parameter int DRAIN_TIMEOUT = 65535,
  parameter bit SCRB_AUTO     = 1'b1,
  localparam int CW           = cnt_width(MAX_OS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scrb_req,
  input  logic          atg_req,
  input  logic          scrb_done,
  input  logic          ds_aw_hs,
  input  logic          ds_ar_hs,
  input  logic          ds_b_hs,
  input  logic          ds_rlast_hs,
  input  logic          err_clr,
  output logic          scrb_enable,
  output logic          atg_enable,
  output logic          addr_block,
  output logic [CW-1:0] wr_os,
  output logic [CW-1:0] rd_os,
  output logic [1:0]    state,
  output logic          drain_to_err,
  output logic          cnt_err
);

  localparam int            TW        = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [TW-1:0] C_TO_LAST = TW'(DRAIN_TIMEOUT - 1);
  localparam logic [CW-1:0] C_THR     = CW'(MAX_OS - 1);

  state_t        r_state, w_state_nxt;
  state_t        r_tgt, w_tgt_nxt, w_tgt_eval;
  logic          r_scrb_req_d, r_first;
  logic [TW-1:0] r_timer;
  logic          r_scrb_en, r_atg_en, r_addr_block;
  logic          r_to_err, r_cnt_err;
  logic          w_scrb_edge, w_drained, w_timeout, w_exit;
  logic          w_wr_err, w_rd_err;

  cl_mem_os_cnt #(.MAX_OS(MAX_OS), .CW(CW)) u_wr_cnt (
    .clk(clk), .rst_n(rst_n), .inc(ds_aw_hs), .dec(ds_b_hs),
    .clr(w_timeout), .cnt(wr_os), .err(w_wr_err)
  );

  cl_mem_os_cnt #(.MAX_OS(MAX_OS), .CW(CW)) u_rd_cnt (
    .clk(clk), .rst_n(rst_n), .inc(ds_ar_hs), .dec(ds_rlast_hs),
    .clr(w_timeout), .cnt(rd_os), .err(w_rd_err)
  );

  assign w_scrb_edge = scrb_req & ~r_scrb_req_d;
  assign w_drained   = (wr_os == '0) && (rd_os == '0);
  assign w_timeout   = (r_state == DRAIN) && !w_drained && (r_timer == C_TO_LAST);
  // a scrub edge during a drain overrides whatever target was pending
  assign w_tgt_eval  = w_scrb_edge ? SCRB : r_tgt;

  always_comb begin
    w_state_nxt = r_state;
    w_tgt_nxt   = r_tgt;
    w_exit      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_scrb_edge || (SCRB_AUTO && r_first)) begin
          w_state_nxt = DRAIN;
          w_tgt_nxt   = SCRB;
        end else if (atg_req) begin
          w_state_nxt = DRAIN;
          w_tgt_nxt   = ATG;
        end
      end
      SCRB: begin
        if (scrb_done) begin
          w_state_nxt = DRAIN;
          w_tgt_nxt   = atg_req ? ATG : IDLE;
        end
      end
      ATG: begin
        if (w_scrb_edge) begin
          w_state_nxt = DRAIN;
          w_tgt_nxt   = SCRB;
        end else if (!atg_req) begin
          w_state_nxt = DRAIN;
          w_tgt_nxt   = IDLE;
        end
      end
      DRAIN: begin
        if (w_drained || w_timeout) begin
          w_state_nxt = w_tgt_eval;
          w_exit      = 1'b1;
        end else begin
          w_tgt_nxt = w_tgt_eval;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_tgt        <= IDLE;
      r_scrb_req_d <= 1'b0;
      r_first      <= 1'b1;
      r_timer      <= '0;
      r_scrb_en    <= 1'b0;
      r_atg_en     <= 1'b0;
      r_addr_block <= 1'b0;
      r_to_err     <= 1'b0;
      r_cnt_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tgt        <= w_tgt_nxt;
      r_scrb_req_d <= scrb_req;
      r_first      <= 1'b0;
      r_timer      <= (r_state == DRAIN) ? r_timer + 1'b1 : '0;
      // enables stay with the old owner until the drain completes
      if (w_exit) begin
        r_scrb_en <= (w_state_nxt == SCRB);
        r_atg_en  <= (w_state_nxt == ATG);
      end
      r_addr_block <= (w_state_nxt == DRAIN) || (wr_os >= C_THR) || (rd_os >= C_THR);
      if (w_timeout)    r_to_err <= 1'b1;
      else if (err_clr) r_to_err <= 1'b0;
      if (w_wr_err || w_rd_err) r_cnt_err <= 1'b1;
      else if (err_clr)         r_cnt_err <= 1'b0;
    end
  end

  assign scrb_enable  = r_scrb_en;
  assign atg_enable   = r_atg_en;
  assign addr_block   = r_addr_block;
  assign state        = r_state;
  assign drain_to_err = r_to_err;
  assign cnt_err      = r_cnt_err;

endmodule

`default_nettype wire

// File: tb/tb_cl_mem_src_ctl.sv
// ============================================================================
// Module : tb_cl_mem_src_ctl
// Brief  : Self-checking bench: directed scenarios plus random traffic
//          against an owner/drain reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cl_mem_src_ctl;

  localparam int MAX = 8;
  localparam int TO  = 16;
  localparam int CW  = $clog2(MAX + 1);

  logic clk, rst_n, scrb_req, atg_req, scrb_done;
  logic aw, ar, b, rl, err_clr;
  logic scrb_enable, atg_enable, addr_block, drain_to_err, cnt_err;
  logic [CW-1:0] wr_os, rd_os;
  logic [1:0] state;

  int n_chk = 0;
  int n_pass = 0;

  // reference model: owner 0=slave 1=scrub 2=ATG, plus a draining flag
  int m_owner, m_tgt, m_wr, m_rd, m_timer;
  bit m_drain, m_block, m_to_err, m_cnt_err, m_first, m_prev;

  cl_mem_src_ctl #(.MAX_OS(MAX), .DRAIN_TIMEOUT(TO), .SCRB_AUTO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .scrb_req(scrb_req), .atg_req(atg_req),
    .scrb_done(scrb_done), .ds_aw_hs(aw), .ds_ar_hs(ar), .ds_b_hs(b),
    .ds_rlast_hs(rl), .err_clr(err_clr), .scrb_enable(scrb_enable),
    .atg_enable(atg_enable), .addr_block(addr_block), .wr_os(wr_os),
    .rd_os(rd_os), .state(state), .drain_to_err(drain_to_err), .cnt_err(cnt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int os_next(input int cur, input bit inc, input bit dec, output bit err);
    err = 1'b0;
    if (inc && !dec) begin
      if (cur == MAX) err = 1'b1;
      else return cur + 1;
    end else if (dec && !inc) begin
      if (cur == 0) err = 1'b1;
      else return cur - 1;
    end
    return cur;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_tgt = 0; m_wr = 0; m_rd = 0; m_timer = 0;
    m_drain = 0; m_block = 0; m_to_err = 0; m_cnt_err = 0;
    m_first = 1; m_prev = 0;
  endtask

  task automatic check_all();
    chk("state", int'(state), m_drain ? 3 : m_owner);
    chk("scrb_enable", int'(scrb_enable), int'(m_owner == 1));
    chk("atg_enable", int'(atg_enable), int'(m_owner == 2));
    chk("addr_block", int'(addr_block), int'(m_block));
    chk("wr_os", int'(wr_os), m_wr);
    chk("rd_os", int'(rd_os), m_rd);
    chk("drain_to_err", int'(drain_to_err), int'(m_to_err));
    chk("cnt_err", int'(cnt_err), int'(m_cnt_err));
  endtask

  // one clock: advance the model on the sampled inputs, then compare
  task automatic cyc();
    bit se, to, we, re, nd;
    int nwr, nrd, t;
    @(posedge clk);
    se = scrb_req && !m_prev;
    to = m_drain && !(m_wr == 0 && m_rd == 0) && (m_timer == TO - 1);
    if (to) begin
      nwr = 0; nrd = 0; we = 0; re = 0;
    end else begin
      nwr = os_next(m_wr, aw, b, we);
      nrd = os_next(m_rd, ar, rl, re);
    end
    nd = m_drain;
    if (!m_drain) begin
      if (m_owner == 0) begin
        if (se || m_first) begin nd = 1; m_tgt = 1; end
        else if (atg_req) begin nd = 1; m_tgt = 2; end
      end else if (m_owner == 1) begin
        if (scrb_done) begin nd = 1; m_tgt = atg_req ? 2 : 0; end
      end else begin
        if (se) begin nd = 1; m_tgt = 1; end
        else if (!atg_req) begin nd = 1; m_tgt = 0; end
      end
      m_timer = 0;
    end else begin
      t = se ? 1 : m_tgt;
      if ((m_wr == 0 && m_rd == 0) || to) begin nd = 0; m_owner = t; end
      else m_tgt = t;
      m_timer = m_timer + 1;
    end
    m_block = nd || (m_wr >= MAX - 1) || (m_rd >= MAX - 1);
    m_drain = nd;
    m_wr = nwr; m_rd = nrd;
    m_to_err  = to ? 1'b1 : (err_clr ? 1'b0 : m_to_err);
    m_cnt_err = (we || re) ? 1'b1 : (err_clr ? 1'b0 : m_cnt_err);
    m_first = 0; m_prev = scrb_req;
    #1;
    check_all();
    aw = 0; ar = 0; b = 0; rl = 0; err_clr = 0;
  endtask

  task automatic reset_release();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 0; scrb_req = 0; atg_req = 0; scrb_done = 0;
    aw = 0; ar = 0; b = 0; rl = 0; err_clr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'(state), 0);
    check_all();
    reset_release();

    // auto scrub after reset, then scrub completes
    cyc(); chk("t1_drain", int'(state), 3);
    cyc(); chk("t1_scrb", int'(state), 1);
    scrb_done = 1; cyc(); chk("t1_done_drain", int'(scrb_enable), 1);
    scrb_done = 0; cyc(); chk("t1_idle", int'(state), 0);

    // ATG drain holds enable until all responses return
    atg_req = 1; cyc(); cyc(); chk("t2_atg_en", int'(atg_enable), 1);
    aw = 1; ar = 1; cyc(); aw = 1; ar = 1; cyc(); aw = 1; cyc(); b = 1; cyc();
    chk("t2_wr", int'(wr_os), 2); chk("t2_rd", int'(rd_os), 2);
    atg_req = 0; cyc(); chk("t2_block", int'(addr_block), 1);
    b = 1; cyc(); b = 1; cyc(); rl = 1; cyc(); rl = 1; cyc();
    chk("t2_held", int'(atg_enable), 1);
    cyc(); chk("t2_released", int'(atg_enable), 0);

    // counter cancel, underflow, clear precedence, saturation
    atg_req = 1; cyc(); cyc();
    repeat (5) begin aw = 1; cyc(); end
    aw = 1; b = 1; cyc(); chk("t3_cancel", int'(wr_os), 5);
    repeat (5) begin b = 1; cyc(); end
    b = 1; cyc(); chk("t3_underflow", int'(cnt_err), 1);
    b = 1; err_clr = 1; cyc(); chk("t3_set_wins", int'(cnt_err), 1);
    err_clr = 1; cyc(); chk("t3_cleared", int'(cnt_err), 0);
    repeat (8) begin aw = 1; cyc(); end
    chk("t3_full", int'(wr_os), MAX); chk("t3_throttle", int'(addr_block), 1);
    aw = 1; cyc(); chk("t3_overflow", int'(cnt_err), 1);
    err_clr = 1; cyc();

    // drain timeout with responses never returned
    atg_req = 0; cyc();
    repeat (15) cyc();
    chk("t4_still_drain", int'(state), 3);
    cyc(); chk("t4_to_err", int'(drain_to_err), 1); chk("t4_wr0", int'(wr_os), 0);
    err_clr = 1; cyc();

    // scrub preempts ATG and hands back afterwards
    atg_req = 1; cyc(); cyc(); chk("t5_atg", int'(state), 2);
    scrb_req = 1; cyc(); scrb_req = 0; cyc(); chk("t5_scrb", int'(scrb_enable), 1);
    scrb_done = 1; cyc(); scrb_done = 0; cyc(); chk("t5_back_atg", int'(state), 2);

    // asynchronous reset mid-drain
    repeat (4) begin aw = 1; cyc(); end
    atg_req = 0; cyc(); chk("t6_wr4", int'(wr_os), 4);
    #3 rst_n = 0;
    #1;
    model_reset();
    chk("t6_async_state", int'(state), 0);
    check_all();
    reset_release();

    for (int i = 0; i < 3000; i++) begin
      aw = !m_block && ($urandom_range(99) < 40);
      ar = !m_block && ($urandom_range(99) < 40);
      b  = ($urandom_range(99) < 30) && (m_wr > 0 || $urandom_range(19) == 0);
      rl = ($urandom_range(99) < 30) && (m_rd > 0 || $urandom_range(19) == 0);
      if ($urandom_range(99) < 8) scrb_req = ~scrb_req;
      if ($urandom_range(99) < 4) atg_req = ~atg_req;
      scrb_done = ($urandom_range(99) < 6);
      err_clr = ($urandom_range(99) < 3);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
